apb_gpio_master: RTL and testbench

APB_GPIO_MASTER -- requirements
Module: apb_gpio_master

---
 rtl/apb_gpio_master_pkg.sv | 28 ++
 rtl/apb_gpio_master_rr_arb2.sv | 37 +++
 rtl/apb_gpio_master.sv | 176 +++++++++++++++++
 tb/tb_apb_gpio_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_master_pkg.sv
// Shared types and constants for the APB GPIO master: FSM states, GPIO
// register map, default PREADY timeout and the access-legality rule.
package apb_gpio_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [3:0] GPIO_PSL = 4'h0;
    localparam logic [3:0] GPIO_DIR = 4'h4;
    localparam logic [3:0] GPIO_SET = 4'h8;
    localparam logic [3:0] GPIO_CLR = 4'hC;

    localparam int DEFAULT_TIMEOUT = 16;

    // Every register is writable; only the pin-state register can be read.
    function automatic logic is_legal(input logic write, input logic [3:0] addr);
        if (write) begin
            return (addr == GPIO_PSL) || (addr == GPIO_DIR) ||
                   (addr == GPIO_SET) || (addr == GPIO_CLR);
        end
        return addr == GPIO_PSL;
    endfunction

endpackage

// File: rtl/apb_gpio_master_rr_arb2.sv
// Two-way round-robin selector. The last-grant pointer starts at 1 so
// requester 0 wins the first contended grant.
module rr_arb2 (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_idx,
    output logic       gnt_any
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_idx = req[1];
        if (req == 2'b11) begin
            gnt_idx = ~last_q;
        end
        gnt_any = en & (|req);
        gnt     = 2'b00;
        if (gnt_any) begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
        last_d = gnt_any ? gnt_idx : last_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_gpio_master.sv
// APB master that serialises GPIO register accesses from two requesters,
// rejecting illegal accesses locally and aborting stalled transfers.
module apb_gpio_master
    import apb_gpio_master_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ack,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWrite,
    output logic [3:0]  PADDR,
    output logic [7:0]  PWDATA,
    input  logic [7:0]  PRDATA,
    input  logic        PREADY
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic          idx_q, idx_d;
    logic          err_q, err_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [3:0]    paddr_q, paddr_d;
    logic [7:0]    pwdata_q, pwdata_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [1:0]    gnt;
    logic          gnt_idx;
    logic          gnt_any;
    logic          sel_write;
    logic [3:0]    sel_addr;
    logic [7:0]    sel_wdata;

    // Gating with PRESETn keeps the combinational ack quiet while reset is held.
    rr_arb2 u_arb (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      ((state_q == ST_IDLE) && PRESETn),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        sel_write = gnt_idx ? req_write[1]    : req_write[0];
        sel_addr  = gnt_idx ? req_addr[7:4]   : req_addr[3:0];
        sel_wdata = gnt_idx ? req_wdata[15:8] : req_wdata[7:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = 8'h00;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    idx_d   = gnt_idx;
                    rdata_d = 8'h00;
                    if (is_legal(sel_write, sel_addr)) begin
                        state_d  = ST_SETUP;
                        err_d    = 1'b0;
                        psel_d   = 1'b1;
                        pwrite_d = sel_write;
                        paddr_d  = sel_addr;
                        pwdata_d = sel_write ? sel_wdata : 8'h00;
                    end else begin
                        // Rejected locally: the bus never sees this access.
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = CW'(1);
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = pwrite_q ? 8'h00 : PRDATA;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = 8'h00;
                    cnt_d   = '0;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                rsp_valid_d = idx_q ? 2'b10 : 2'b01;
                rsp_rdata_d = rdata_q;
                rsp_err_d   = err_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            idx_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 4'h0;
            pwdata_q    <= 8'h00;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ack   = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWrite    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_gpio_master.sv
// Directed scoreboard bench for apb_gpio_master: expected grants and
// responses are queued at stimulus time and checked as the DUT produces them.
module tb_apb_gpio_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ack;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWrite;
    logic [3:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;
    logic        PREADY = 1'b1;

    apb_gpio_master #(.TIMEOUT(16)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWrite    (PWrite),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int idx;
        int write;
        int addr;
        int wdata;
        int rdata;
        int err;
        int lat;
        int setups;
        int accs;
    } exp_t;

    exp_t rsp_q[$];
    int   ack_q[$];
    exp_t mon_e;
    int   mon_a;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ack_cyc = 0;
    int ack_count = 0;
    int rsp_count = 0;
    int setup_seen = 0;
    int acc_seen = 0;
    int rdy_mode = 0;   // 0: PREADY tied high, 1: held low, 2: high on ACCESS cycle rdy_at
    int rdy_at = 0;

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Monitor and scoreboard, sampling on the falling edge.
    always @(negedge PCLK) begin
        cyc++;
        if (!PRESETn) begin
            setup_seen = 0;
            acc_seen   = 0;
        end else begin
            if (PSEL) begin
                if (rsp_q.size() == 0) begin
                    check("psel_unexpected", 1, 0);
                end else begin
                    check("paddr", int'(PADDR), rsp_q[0].addr);
                    check("pwdata", int'(PWDATA), rsp_q[0].wdata);
                    check("pwrite", int'(PWrite), rsp_q[0].write);
                end
                if (PENABLE) acc_seen++;
                else setup_seen++;
            end else begin
                check("penable_without_psel", int'(PENABLE), 0);
            end
            if (rsp_valid != 2'b00) begin
                rsp_count++;
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", int'(rsp_valid), 0);
                end else begin
                    mon_e = rsp_q.pop_front();
                    check("rsp_valid", int'(rsp_valid), (mon_e.idx != 0) ? 2 : 1);
                    check("rsp_rdata", int'(rsp_rdata), mon_e.rdata);
                    check("rsp_err", int'(rsp_err), mon_e.err);
                    check("latency", cyc - ack_cyc, mon_e.lat);
                    check("setup_cycles", setup_seen, mon_e.setups);
                    check("access_cycles", acc_seen, mon_e.accs);
                    $display("txn req%0d %s addr=%0h rdata=%02h err=%0d lat=%0d access=%0d",
                             mon_e.idx, (mon_e.write != 0) ? "wr" : "rd", mon_e.addr,
                             rsp_rdata, rsp_err, cyc - ack_cyc, acc_seen);
                end
                setup_seen = 0;
                acc_seen   = 0;
            end
            if (req_ack != 2'b00) begin
                ack_count++;
                ack_cyc = cyc;
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", int'(req_ack), 0);
                end else begin
                    mon_a = ack_q.pop_front();
                    check("req_ack", int'(req_ack), (mon_a != 0) ? 2 : 1);
                end
            end
        end
        PREADY = (rdy_mode == 0) ||
                 (rdy_mode == 2 && PSEL && PENABLE && acc_seen == rdy_at);
    end

    task automatic push(input int idx, input int wr, input int addr, input int wdata,
                        input int rdata, input int err, input int lat,
                        input int setups, input int accs);
        exp_t e;
        e.idx    = idx;
        e.write  = wr;
        e.addr   = addr;
        e.wdata  = (wr != 0) ? wdata : 0;
        e.rdata  = rdata;
        e.err    = err;
        e.lat    = lat;
        e.setups = setups;
        e.accs   = accs;
        rsp_q.push_back(e);
        ack_q.push_back(idx);
    endtask

    task automatic drive(input int n, input int wr, input int addr, input int wdata);
        req_valid[n]          = 1'b1;
        req_write[n]          = 1'(wr);
        req_addr[4*n +: 4]    = 4'(addr);
        req_wdata[8*n +: 8]   = 8'(wdata);
    endtask

    task automatic wait_acks(input int target);
        for (int i = 0; i < 200 && ack_count < target; i++) @(posedge PCLK);
        check("ack_count", ack_count, target);
        #1;
    endtask

    task automatic wait_rsps(input int target);
        for (int i = 0; i < 200 && rsp_count < target; i++) @(posedge PCLK);
        check("rsp_count", rsp_count, target);
        #1;
    endtask

    task automatic single(input int n, input int wr, input int addr, input int wdata,
                          input int rdata, input int err, input int lat,
                          input int setups, input int accs);
        int a0;
        int r0;
        a0 = ack_count;
        r0 = rsp_count;
        push(n, wr, addr, wdata, rdata, err, lat, setups, accs);
        drive(n, wr, addr, wdata);
        wait_acks(a0 + 1);
        req_valid = 2'b00;
        wait_rsps(r0 + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        PRESETn   = 1'b0;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = 8'h00;
        req_wdata = 16'h0000;
        PRDATA    = 8'h00;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_psel", int'(PSEL), 0);
        check("rst_penable", int'(PENABLE), 0);
        check("rst_pwrite", int'(PWrite), 0);
        check("rst_paddr", int'(PADDR), 0);
        check("rst_pwdata", int'(PWDATA), 0);
        check("rst_req_ack", int'(req_ack), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_rdata", int'(rsp_rdata), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        req_valid = 2'b00;
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;

        // Best-case write, then read with PREADY tied high.
        single(0, 1, 4'h4, 8'hA5, 0, 0, 4, 1, 1);
        PRDATA = 8'h3C;
        single(1, 0, 4'h0, 0, 8'h3C, 0, 4, 1, 1);

        // Both requesters held valid: alternate 0,1,0,1 back to back.
        a0 = ack_count;
        r0 = rsp_count;
        push(0, 1, 4'h8, 8'h11, 0, 0, 4, 1, 1);
        push(1, 1, 4'hC, 8'h22, 0, 0, 4, 1, 1);
        push(0, 1, 4'h8, 8'h11, 0, 0, 4, 1, 1);
        push(1, 1, 4'hC, 8'h22, 0, 0, 4, 1, 1);
        drive(0, 1, 4'h8, 8'h11);
        drive(1, 1, 4'hC, 8'h22);
        wait_acks(a0 + 4);
        req_valid = 2'b00;
        wait_rsps(r0 + 4);

        // Illegal accesses: no bus activity, error response two cycles after ack.
        single(0, 0, 4'h8, 0, 0, 1, 2, 0, 0);
        single(1, 1, 4'h6, 8'h77, 0, 1, 2, 0, 0);

        // PREADY stuck low: 16 ACCESS cycles then timeout error.
        rdy_mode = 1;
        PRDATA   = 8'h77;
        single(0, 0, 4'h0, 0, 0, 1, 19, 1, 16);

        // PREADY on the 16th ACCESS cycle wins over the timeout.
        rdy_mode = 2;
        rdy_at   = 16;
        single(1, 0, 4'h0, 0, 8'h77, 0, 19, 1, 16);

        // Reset in the middle of ACCESS abandons the transfer silently.
        rdy_mode = 1;
        a0 = ack_count;
        r0 = rsp_count;
        push(0, 1, 4'h8, 8'h99, 0, 0, 0, 1, 0);
        drive(0, 1, 4'h8, 8'h99);
        wait_acks(a0 + 1);
        req_valid = 2'b00;
        for (int i = 0; i < 20 && !(PSEL && PENABLE); i++) begin
            @(posedge PCLK);
            #1;
        end
        check("access_reached", int'(PSEL && PENABLE), 1);
        repeat (2) @(posedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        check("rst_mid_psel", int'(PSEL), 0);
        check("rst_mid_penable", int'(PENABLE), 0);
        void'(rsp_q.pop_front());
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn  = 1'b1;
        rdy_mode = 0;
        repeat (3) @(posedge PCLK);
        #1;
        check("no_rsp_after_reset", rsp_count, r0);

        // Pointer is back at 1 after reset, so requester 0 wins first again.
        PRDATA = 8'h81;
        a0 = ack_count;
        r0 = rsp_count;
        push(0, 0, 4'h0, 0, 8'h81, 0, 4, 1, 1);
        push(1, 0, 4'h0, 0, 8'h81, 0, 4, 1, 1);
        drive(0, 0, 4'h0, 0);
        drive(1, 0, 4'h0, 0);
        wait_acks(a0 + 2);
        req_valid = 2'b00;
        wait_rsps(r0 + 2);

        repeat (5) @(posedge PCLK);
        #1;
        check("ack_queue_empty", ack_q.size(), 0);
        check("rsp_queue_empty", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
